// File: rtl/phase_seq.sv
// phase_seq: five-phase instruction sequencer (fetch, read, execute, memory, writeback)
// with memory-handshake watchdog, sticky halt/fault and saturating retire counter.
module phase_seq #(
    parameter int unsigned WD_LIMIT = 255
) (
    input  logic        clk,
    input  logic        n_rst,
    output logic [4:0]  phase,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        mem_op,
    input  logic        dmem_ack,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        halt,
    output logic        halted,
    output logic        fault,
    output logic [15:0] icount
);

    typedef enum logic [2:0] {
        S_F,
        S_R,
        S_X,
        S_M,
        S_W,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [7:0] WD_MAX = 8'(WD_LIMIT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [15:0] icount_q, icount_d;
    logic [7:0]  wd_q, wd_d;

    // Branch targets are word aligned; the low two bits are dropped.
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^br_target[1:0];

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_F;
            pc_q     <= '0;
            ir_q     <= '0;
            icount_q <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            icount_q <= icount_d;
            wd_q     <= wd_d;
        end
    end

    // Next-state, watchdog and writeback updates.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        icount_d = icount_q;
        wd_d     = wd_q;
        unique case (state_q)
            S_F: begin
                if (wd_q == WD_MAX) begin
                    state_d = S_FAULT;
                end else if (imem_ack) begin
                    state_d = S_R;
                    ir_d    = imem_rdata;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            S_R: state_d = S_X;
            S_X: begin
                state_d = S_M;
                wd_d    = '0;
            end
            S_M: begin
                if (!mem_op) begin
                    state_d = S_W;
                end else if (wd_q == WD_MAX) begin
                    state_d = S_FAULT;
                end else if (dmem_ack) begin
                    state_d = S_W;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            S_W: begin
                pc_d = br_taken ? {br_target[31:2], 2'b00}
                                : pc_q + 32'd4;
                if (icount_q != 16'hFFFF) begin
                    icount_d = icount_q + 16'd1;
                end
                wd_d    = '0;
                state_d = halt ? S_HALT : S_F;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // One-hot phase decode; terminal states show no phase.
    always_comb begin
        phase = 5'b00000;
        unique case (state_q)
            S_F:     phase = 5'b00001;
            S_R:     phase = 5'b00010;
            S_X:     phase = 5'b00100;
            S_M:     phase = 5'b01000;
            S_W:     phase = 5'b10000;
            default: phase = 5'b00000;
        endcase
    end

    assign pc        = pc_q;
    assign ir        = ir_q;
    assign imem_addr = pc_q;
    assign imem_req  = (state_q == S_F);
    assign halted    = (state_q == S_HALT);
    assign fault     = (state_q == S_FAULT);
    assign icount    = icount_q;

endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq: random and directed stimulus for phase_seq,
// checked every cycle against a behavioural instruction-level model.
module tb_phase_seq;

    localparam int WD = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [4:0]  phase;
    logic [31:0] pc, ir, imem_addr, imem_rdata, br_target;
    logic        imem_req, imem_ack, mem_op, dmem_ack;
    logic        br_taken, halt, halted, fault;
    logic [15:0] icount;

    int checks = 0;
    int failures = 0;

    // model: where the instruction is (0 F,1 R,2 X,3 M,4 W,5 halted,6 faulted)
    int          m_where;
    int          m_waited;
    logic [31:0] m_pc, m_ir;
    int          m_retired;

    phase_seq #(.WD_LIMIT(WD)) dut (
        .clk(clk), .n_rst(n_rst), .phase(phase), .pc(pc), .ir(ir),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .mem_op(mem_op),
        .dmem_ack(dmem_ack), .br_taken(br_taken), .br_target(br_target),
        .halt(halt), .halted(halted), .fault(fault), .icount(icount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_where = 0;
        m_waited = 0;
        m_pc = 0;
        m_ir = 0;
        m_retired = 0;
    endtask

    task automatic model_step();
        case (m_where)
            0: begin
                if (m_waited >= WD) m_where = 6;
                else if (imem_ack) begin
                    m_ir = imem_rdata;
                    m_where = 1;
                end else m_waited++;
            end
            1: m_where = 2;
            2: begin
                m_where = 3;
                m_waited = 0;
            end
            3: begin
                if (!mem_op) m_where = 4;
                else if (m_waited >= WD) m_where = 6;
                else if (dmem_ack) m_where = 4;
                else m_waited++;
            end
            4: begin
                if (br_taken) m_pc = br_target & 32'hFFFF_FFFC;
                else m_pc = m_pc + 32'd4;
                if (m_retired < 65535) m_retired++;
                m_waited = 0;
                m_where = halt ? 5 : 0;
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        logic [31:0] ph;
        ph = (m_where < 5) ? (32'd1 << m_where) : 32'd0;
        chk("phase", 32'(phase), ph);
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("ir", ir, m_ir);
        chk("imem_req", 32'(imem_req), 32'(m_where == 0));
        chk("halted", 32'(halted), 32'(m_where == 5));
        chk("fault", 32'(fault), 32'(m_where == 6));
        chk("icount", 32'(icount), 32'(m_retired));
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cyc();
        compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        imem_ack = 0;
        dmem_ack = 0;
        mem_op = 0;
        br_taken = 0;
        br_target = 0;
        halt = 0;
        imem_rdata = 0;
    endtask

    task automatic do_reset();
        idle();
        n_rst = 0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        chk("rst_phase", 32'(phase), 32'd1);
        chk("rst_req", 32'(imem_req), 32'd1);
        n_rst = 1;
    endtask

    task automatic run_instr(input int adly, input bit mop, input int ddly,
                             input bit br, input logic [31:0] tgt,
                             input bit hlt, input bit hlt_x,
                             input logic [31:0] rdata,
                             output int fcyc, output int mcyc);
        int fn = 0;
        int mn = 0;
        bit done = 0;
        fcyc = 0;
        mcyc = 0;
        for (int g = 0; g < 100 && !done; g++) begin
            idle();
            mem_op = mop;
            imem_rdata = rdata;
            if (phase == 5'b00001) fcyc++;
            if (phase == 5'b01000) mcyc++;
            case (m_where)
                0: begin
                    imem_ack = (fn >= adly);
                    fn++;
                end
                2: halt = hlt_x;
                3: begin
                    dmem_ack = (mn >= ddly);
                    mn++;
                end
                4: begin
                    br_taken = br;
                    br_target = tgt;
                    halt = hlt;
                end
                default: ;
            endcase
            done = (m_where == 4);
            cyc();
            if (m_where >= 5) done = 1;
        end
        if (!done) chk("instr_timeout", 32'd0, 32'd1);
    endtask

    int fc, mc;
    logic [4:0] seq [6];

    initial begin
        seq = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd1};
        idle();
        @(negedge clk);
        do_reset();
        chk("rst_pc", pc, 32'd0);
        chk("rst_icount", 32'(icount), 32'd0);

        // zero-wait run, ack tied to request
        imem_rdata = 32'h1111_1111;
        for (int i = 0; i < 6; i++) begin
            imem_ack = imem_req;
            chk("zw_seq", 32'(phase), 32'(seq[i]));
            if (i < 5) cyc();
        end
        chk("zw_pc1", pc, 32'd4);
        chk("zw_ir", ir, 32'h1111_1111);
        run_instr(0, 0, 0, 0, 0, 0, 0, 32'h1111_1111, fc, mc);
        run_instr(0, 0, 0, 0, 0, 0, 0, 32'h1111_1111, fc, mc);
        chk("zw_icount", 32'(icount), 32'd3);
        chk("zw_pc3", pc, 32'd12);

        // wait states
        run_instr(3, 1, 2, 0, 0, 0, 0, 32'hA5A5_0001, fc, mc);
        chk("wait_f_len", fc, 32'd4);
        chk("wait_m_len", mc, 32'd3);
        chk("wait_pc", pc, 32'd16);

        // branch, then wrap
        run_instr(1, 0, 0, 1, 32'h0000_0103, 0, 0, 32'h2, fc, mc);
        chk("br_pc", pc, 32'h0000_0100);
        run_instr(0, 1, 0, 1, 32'hFFFF_FFFF, 0, 0, 32'h3, fc, mc);
        chk("br_pc_top", pc, 32'hFFFF_FFFC);
        run_instr(0, 0, 0, 0, 32'h0000_0040, 0, 0, 32'h4, fc, mc);
        chk("wrap_pc", pc, 32'd0);

        // halt only honoured in W
        run_instr(0, 0, 0, 0, 0, 0, 1, 32'h5, fc, mc);
        chk("halt_x_ignored", 32'(halted), 32'd0);
        chk("halt_x_phase", 32'(phase), 32'd1);
        run_instr(0, 0, 0, 0, 0, 1, 0, 32'h6, fc, mc);
        chk("halt_w", 32'(halted), 32'd1);
        chk("halt_phase", 32'(phase), 32'd0);
        imem_ack = 1;
        for (int i = 0; i < 3; i++) cyc();
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_req", 32'(imem_req), 32'd0);

        // fetch watchdog
        do_reset();
        run_instr(100, 0, 0, 0, 0, 0, 0, 32'h7, fc, mc);
        chk("wd_fault", 32'(fault), 32'd1);
        chk("wd_phase", 32'(phase), 32'd0);
        chk("wd_req", 32'(imem_req), 32'd0);
        chk("wd_f_len", fc, 32'd5);
        do_reset();
        run_instr(WD, 0, 0, 0, 0, 0, 0, 32'h8, fc, mc);
        chk("wd_limit_ack", 32'(fault), 32'd1);
        imem_ack = 1;
        dmem_ack = 1;
        for (int i = 0; i < 4; i++) cyc();
        chk("wd_sticky", 32'(fault), 32'd1);

        // memory watchdog
        do_reset();
        run_instr(0, 1, 100, 0, 0, 0, 0, 32'h9, fc, mc);
        chk("wd_m_fault", 32'(fault), 32'd1);
        chk("wd_m_len", mc, 32'd5);

        // async reset in the middle of an M wait
        do_reset();
        run_instr(0, 0, 0, 0, 0, 0, 0, 32'hA, fc, mc);
        idle();
        imem_ack = 1;
        mem_op = 1;
        for (int g = 0; g < 20 && !(m_where == 3 && m_waited > 0); g++)
            cyc();
        chk("mw_reached", 32'(phase), 32'd8);
        #1;
        n_rst = 0;
        model_reset();
        #1;
        chk("ar_phase", 32'(phase), 32'd1);
        chk("ar_pc", pc, 32'd0);
        chk("ar_icount", 32'(icount), 32'd0);
        idle();
        #1;
        n_rst = 1;
        cyc();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_where >= 5 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                imem_ack = ($urandom_range(0, 2) != 0);
                dmem_ack = ($urandom_range(0, 2) != 0);
                if (m_where <= 1) mem_op = 1'($urandom_range(0, 1));
                br_taken = 1'($urandom_range(0, 1));
                br_target = $urandom;
                halt = ($urandom_range(0, 40) == 0);
                imem_rdata = $urandom;
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
